// File: rtl/pc_seq_pkg.sv
// Package: pc_seq_pkg
// Shared types and encodings for the fetch-stage sequencer.
//   seqState_t - sequencer state (BOOT, RUN, MEMWAIT, HALTED)
//   PCSEL_*    - next-PC source select encodings
//   REG_W      - register specifier width
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    MEMWAIT = 2'd2,
    HALTED  = 2'd3
  } seqState_t;

  localparam logic [1:0] PCSEL_SEQ = 2'b00;
  localparam logic [1:0] PCSEL_BR  = 2'b01;
  localparam logic [1:0] PCSEL_JMP = 2'b10;

  localparam int unsigned REG_W = 5;

endpackage

// File: rtl/load_use_detect.sv
// Module: load_use_detect
// Combinational load-use hazard comparator between the ID instruction and a
// load in EX. Register 0 never creates a hazard.
//   idRs, idRt   - ID-stage source registers
//   idUsesRt     - ID instruction actually reads rt
//   exMemRead    - EX instruction is a load
//   exRt         - load destination register
//   hazard       - ID must stall one cycle behind the load
module load_use_detect
  import pc_seq_pkg::*;
(
  input  logic [REG_W-1:0] idRs,
  input  logic [REG_W-1:0] idRt,
  input  logic             idUsesRt,
  input  logic             exMemRead,
  input  logic [REG_W-1:0] exRt,
  output logic             hazard
);

  assign hazard = exMemRead && (exRt != '0) &&
                  ((exRt == idRs) || (idUsesRt && (exRt == idRt)));

endmodule

// File: rtl/pc_sequencer.sv
// Module: pc_sequencer
// Fetch-stage controller: PC write enable / next-PC select, IF/ID write and
// flush, ID/EX bubble. Handles boot hold, load-use stalls, ID redirects,
// instruction-memory wait states with a watchdog, and halt.
// Optional feature macro: STALL_CNT_EN adds the saturating stallCycles port.
//   clk, rst        - clock, asynchronous active-high reset
//   imemReady       - instruction memory word valid this cycle
//   idRs/idRt/idUsesRt, exMemRead/exRt - hazard inputs
//   idBranchTaken, idJump, idHalt      - ID-stage control
//   pcWrite, pcSel, ifidWrite, ifidFlush, idexBubble - Mealy controls
//   halted, memTimeout                 - registered status
//   stallCycles     - (STALL_CNT_EN) pcWrite=0 cycles in RUN/MEMWAIT
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned BOOT_HOLD   = 2,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imemReady,
  input  logic [REG_W-1:0] idRs,
  input  logic [REG_W-1:0] idRt,
  input  logic             idUsesRt,
  input  logic             exMemRead,
  input  logic [REG_W-1:0] exRt,
  input  logic             idBranchTaken,
  input  logic             idJump,
  input  logic             idHalt,
  output logic             pcWrite,
  output logic [1:0]       pcSel,
  output logic             ifidWrite,
  output logic             ifidFlush,
  output logic             idexBubble,
  output logic             halted,
  output logic             memTimeout
`ifdef STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stallCycles
`endif
);

  localparam int unsigned BOOT_W = $clog2(BOOT_HOLD + 1);
  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  seqState_t         state, stateNext;
  logic [BOOT_W-1:0] bootCnt, bootCntNext;
  logic [WAIT_W-1:0] waitCnt, waitCntNext;
  logic              timeoutNext;
  logic              hazard;

  load_use_detect uLud (
    .idRs      (idRs),
    .idRt      (idRt),
    .idUsesRt  (idUsesRt),
    .exMemRead (exMemRead),
    .exRt      (exRt),
    .hazard    (hazard)
  );

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BOOT;
      bootCnt    <= '0;
      waitCnt    <= '0;
      halted     <= 1'b0;
      memTimeout <= 1'b0;
    end else begin
      state      <= stateNext;
      bootCnt    <= bootCntNext;
      waitCnt    <= waitCntNext;
      halted     <= (stateNext == HALTED);
      memTimeout <= timeoutNext;
    end
  end

  // Next-state and Mealy output decode.
  always_comb begin
    stateNext   = state;
    bootCntNext = bootCnt;
    waitCntNext = waitCnt;
    timeoutNext = memTimeout;
    pcWrite     = 1'b1;
    pcSel       = PCSEL_SEQ;
    ifidWrite   = 1'b1;
    ifidFlush   = 1'b0;
    idexBubble  = 1'b0;

    case (state)
      BOOT: begin
        pcWrite    = 1'b0;
        ifidWrite  = 1'b0;
        ifidFlush  = 1'b1;
        idexBubble = 1'b1;
        if (bootCnt == BOOT_W'(BOOT_HOLD - 1)) begin
          stateNext   = RUN;
          bootCntNext = '0;
        end else begin
          bootCntNext = bootCnt + BOOT_W'(1);
        end
      end

      RUN, MEMWAIT: begin
        if (hazard) begin
          // Hold everything behind the load; wait counter and state freeze.
          pcWrite    = 1'b0;
          ifidWrite  = 1'b0;
          idexBubble = 1'b1;
        end else if (idJump || idBranchTaken) begin
          pcSel       = idJump ? PCSEL_JMP : PCSEL_BR;
          ifidFlush   = 1'b1;
          stateNext   = RUN;
          waitCntNext = '0;
        end else if (idHalt) begin
          pcWrite   = 1'b0;
          ifidFlush = 1'b1;
          stateNext = HALTED;
        end else if (!imemReady) begin
          pcWrite   = 1'b0;
          ifidFlush = 1'b1;
          // This is the (waitCnt+1)-th consecutive miss.
          if (waitCnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
            stateNext   = HALTED;
            timeoutNext = 1'b1;
          end else begin
            stateNext   = MEMWAIT;
            waitCntNext = waitCnt + WAIT_W'(1);
          end
        end else begin
          stateNext   = RUN;
          waitCntNext = '0;
        end
      end

      HALTED: begin
        pcWrite    = 1'b0;
        ifidWrite  = 1'b0;
        ifidFlush  = 1'b1;
        idexBubble = 1'b1;
      end

      default: stateNext = BOOT;
    endcase
  end

`ifdef STALL_CNT_EN
  // Saturating count of stalled fetch cycles while running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCycles <= '0;
    end else if (((state == RUN) || (state == MEMWAIT)) && !pcWrite &&
                 (stallCycles != '1)) begin
      stallCycles <= stallCycles + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed test-plan sequences with literal
// expectations, then randomized stimulus checked every cycle against a
// behavioural model (boot countdown, consecutive-miss count, halt flag).
module tb_pc_sequencer;

  localparam int unsigned BOOT_HOLD   = 2;
  localparam int unsigned MEM_TIMEOUT = 16;
  localparam int unsigned CNT_W       = 32;

  logic       clk;
  logic       rst;
  logic       imemReady;
  logic [4:0] idRs, idRt, exRt;
  logic       idUsesRt, exMemRead, idBranchTaken, idJump, idHalt;
  logic       pcWrite, ifidWrite, ifidFlush, idexBubble, halted, memTimeout;
  logic [1:0] pcSel;
`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] stallCycles;
`endif

  pc_sequencer #(
    .BOOT_HOLD   (BOOT_HOLD),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imemReady     (imemReady),
    .idRs          (idRs),
    .idRt          (idRt),
    .idUsesRt      (idUsesRt),
    .exMemRead     (exMemRead),
    .exRt          (exRt),
    .idBranchTaken (idBranchTaken),
    .idJump        (idJump),
    .idHalt        (idHalt),
    .pcWrite       (pcWrite),
    .pcSel         (pcSel),
    .ifidWrite     (ifidWrite),
    .ifidFlush     (ifidFlush),
    .idexBubble    (idexBubble),
    .halted        (halted),
    .memTimeout    (memTimeout)
`ifdef STALL_CNT_EN
    ,
    .stallCycles   (stallCycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nErrors = 0;

  // Model state: cycles of boot hold left, consecutive misses, halt/timeout flags.
  int           bootLeft;
  int           missRun;
  bit           mHalted;
  bit           mTimeout;
  longint       mStall;

  // Last values sampled from the DUT (at negedge).
  bit           sPcWrite, sIfidWrite, sFlush, sBubble, sHalted, sTimeout;
  int           sPcSel;

  function automatic void check(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nErrors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endfunction

  function automatic void resetModel();
    bootLeft = BOOT_HOLD;
    missRun  = 0;
    mHalted  = 1'b0;
    mTimeout = 1'b0;
    mStall   = 0;
  endfunction

  task automatic setIn(input bit rdy, input logic [4:0] rs, input logic [4:0] rt,
                       input bit uses, input bit exr, input logic [4:0] ert,
                       input bit br, input bit jmp, input bit hlt);
    imemReady = rdy; idRs = rs; idRt = rt; idUsesRt = uses;
    exMemRead = exr; exRt = ert; idBranchTaken = br; idJump = jmp; idHalt = hlt;
  endtask

  task automatic idle();
    setIn(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // One clock cycle: predict, compare at negedge, advance model at posedge.
  task automatic step();
    bit hz, redir;
    bit ePcWrite, eIfidWrite, eFlush, eBubble;
    int ePcSel;
    if (rst) resetModel();
    hz    = exMemRead && (exRt != 0) &&
            ((exRt == idRs) || (idUsesRt && (exRt == idRt)));
    redir = idJump || idBranchTaken;
    ePcWrite = 1'b1; ePcSel = 0; eIfidWrite = 1'b1; eFlush = 1'b0; eBubble = 1'b0;
    if (bootLeft > 0 || mHalted) begin
      ePcWrite = 1'b0; eIfidWrite = 1'b0; eFlush = 1'b1; eBubble = 1'b1;
    end else if (hz) begin
      ePcWrite = 1'b0; eIfidWrite = 1'b0; eBubble = 1'b1;
    end else if (redir) begin
      ePcSel = idJump ? 2 : 1; eFlush = 1'b1;
    end else if (idHalt || !imemReady) begin
      ePcWrite = 1'b0; eFlush = 1'b1;
    end

    @(negedge clk);
    sPcWrite = pcWrite; sPcSel = int'(pcSel); sIfidWrite = ifidWrite;
    sFlush = ifidFlush; sBubble = idexBubble; sHalted = halted; sTimeout = memTimeout;
    check("pcWrite",    int'(pcWrite),    int'(ePcWrite));
    check("pcSel",      int'(pcSel),      ePcSel);
    check("ifidWrite",  int'(ifidWrite),  int'(eIfidWrite));
    check("ifidFlush",  int'(ifidFlush),  int'(eFlush));
    check("idexBubble", int'(idexBubble), int'(eBubble));
    check("halted",     int'(halted),     int'(mHalted));
    check("memTimeout", int'(memTimeout), int'(mTimeout));
`ifdef STALL_CNT_EN
    check("stallCycles", int'(stallCycles), int'(mStall));
`endif

    @(posedge clk);
    if (rst) begin
      resetModel();
    end else if (bootLeft > 0) begin
      bootLeft--;
    end else if (!mHalted) begin
      if (!ePcWrite && mStall < 64'hFFFF_FFFF) mStall++;
      if (hz) begin
      end else if (redir) begin
        missRun = 0;
      end else if (idHalt) begin
        mHalted = 1'b1;
      end else if (!imemReady) begin
        missRun++;
        if (missRun == int'(MEM_TIMEOUT)) begin
          mHalted  = 1'b1;
          mTimeout = 1'b1;
        end
      end else begin
        missRun = 0;
      end
    end
    #1;
  endtask

  task automatic bootUp();
    rst = 1'b1; idle(); step();
    rst = 1'b0;
    for (int i = 0; i < int'(BOOT_HOLD); i++) step();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    resetModel();
    @(posedge clk); #1;

    // Reset values.
    step();
    check("rst_pcWrite",    int'(sPcWrite), 0);
    check("rst_ifidFlush",  int'(sFlush), 1);
    check("rst_idexBubble", int'(sBubble), 1);
    check("rst_halted",     int'(sHalted), 0);

    // Boot hold then first fetch.
    rst = 1'b0;
    step(); check("boot1_pcWrite", int'(sPcWrite), 0);
    step(); check("boot2_pcWrite", int'(sPcWrite), 0);
    step(); check("boot3_pcWrite", int'(sPcWrite), 1);
    check("boot3_pcSel", sPcSel, 0);

    // Load-use stall, then load advances; exRt=0 never stalls.
    setIn(1'b1, 5'd5, 5'd7, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0); step();
    check("lu_pcWrite", int'(sPcWrite), 0);
    check("lu_ifidWrite", int'(sIfidWrite), 0);
    check("lu_idexBubble", int'(sBubble), 1);
    idle(); step(); check("lu_after_pcWrite", int'(sPcWrite), 1);
    setIn(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0); step();
    check("lu_r0_pcWrite", int'(sPcWrite), 1);

    // Branch and jump together while memory is not ready: jump wins.
    setIn(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0); step();
    check("redir_pcWrite", int'(sPcWrite), 1);
    check("redir_pcSel", sPcSel, 2);
    check("redir_flush", int'(sFlush), 1);
    idle(); step(); check("redir_run_pcWrite", int'(sPcWrite), 1);

    // Three wait cycles, then normal fetch without timeout.
    for (int i = 0; i < 3; i++) begin
      idle(); imemReady = 1'b0; step();
      check("wait3_pcWrite", int'(sPcWrite), 0);
    end
    idle(); step();
    check("wait3_done_pcWrite", int'(sPcWrite), 1);
    check("wait3_done_timeout", int'(sTimeout), 0);

    // Watchdog timeout.
    for (int i = 0; i < int'(MEM_TIMEOUT); i++) begin
      idle(); imemReady = 1'b0; step();
    end
    check("to_edge_timeout", int'(sTimeout), 0);
    step();
    check("to_timeout", int'(sTimeout), 1);
    check("to_halted", int'(sHalted), 1);
    idle(); step(); step();
    check("to_hold_timeout", int'(sTimeout), 1);
    check("to_hold_pcWrite", int'(sPcWrite), 0);

    // Reset out of timeout, boot, then halt.
    bootUp();
    idle(); idHalt = 1'b1; step();
    check("halt_pcWrite", int'(sPcWrite), 0);
    check("halt_bubble", int'(sBubble), 0);
    check("halt_halted_now", int'(sHalted), 0);
    idle(); step();
    check("halt_halted_next", int'(sHalted), 1);
    rst = 1'b1; step();
    check("halt_rst_halted", int'(sHalted), 0);
    check("halt_rst_flush", int'(sFlush), 1);
    rst = 1'b0; step(); step(); step();
    check("reboot_pcWrite", int'(sPcWrite), 1);

    // Reset in the middle of a wait.
    for (int i = 0; i < 5; i++) begin idle(); imemReady = 1'b0; step(); end
    rst = 1'b1; step();
    check("mw_rst_pcWrite", int'(sPcWrite), 0);
    rst = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      imemReady     = ($urandom_range(0, 9) != 0);
      idRs          = 5'($urandom_range(0, 3));
      idRt          = 5'($urandom_range(0, 3));
      idUsesRt      = 1'($urandom_range(0, 1));
      exMemRead     = ($urandom_range(0, 4) == 0);
      exRt          = 5'($urandom_range(0, 3));
      idBranchTaken = ($urandom_range(0, 9) == 0);
      idJump        = ($urandom_range(0, 19) == 0);
      idHalt        = ($urandom_range(0, 49) == 0);
      if (mHalted) rst = ($urandom_range(0, 7) == 0);
      else         rst = ($urandom_range(0, 499) == 0);
      step();
    end

    // Long miss burst inside random phase conditions.
    bootUp();
    for (int i = 0; i < int'(MEM_TIMEOUT) + 2; i++) begin
      idle(); imemReady = 1'b0; step();
    end
    check("final_timeout", int'(sTimeout), 1);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
